// File: rtl/coll_det_pkg.sv
// -----------------------------------------------------------------------------
// coll_det_pkg
//
// Shared definitions for the collision-detection datapath blocks.
//   W            : default coordinate width (unsigned coordinates)
//   AXIS_*       : separating-axis encodings reported by the overlap checker
//   LAST_IDX     : index of the final interval compare (six compares, 0..5)
//   aabb_state_t : overlap-checker control states
//   aabb_box_t   : one box as {min corner, max corner}, each packed {z,y,x}
//   idx_to_axis  : maps a compare index to the axis it tests
// -----------------------------------------------------------------------------
package coll_det_pkg;

    localparam int W = 32;

    localparam logic [1:0] AXIS_X    = 2'd0;
    localparam logic [1:0] AXIS_Y    = 2'd1;
    localparam logic [1:0] AXIS_Z    = 2'd2;
    localparam logic [1:0] AXIS_NONE = 2'd3;

    localparam logic [2:0] LAST_IDX  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } aabb_state_t;

    typedef struct packed {
        logic [3*W-1:0] bmin;
        logic [3*W-1:0] bmax;
    } aabb_box_t;

    // Two compares per axis: indices {0,1}->x, {2,3}->y, {4,5}->z.
    function automatic logic [1:0] idx_to_axis(input logic [2:0] idx);
        return idx[2:1];
    endfunction

endpackage

// File: rtl/aabb_cmp_sel.sv
// -----------------------------------------------------------------------------
// aabb_cmp_sel
//
// Combinational operand selector for the sequential AABB overlap checker.
// For compare index idx (0..5) it picks the axis idx/2 and the pair (hi, lo)
// whose difference hi - lo must not borrow for the boxes to overlap on that
// side of the axis:
//   even idx : hi = b_max[axis], lo = a_min[axis]
//   odd  idx : hi = a_max[axis], lo = b_min[axis]
//
// Ports
//   idx      in   3     compare index
//   a_min    in   3*W   box A min corner {z,y,x}
//   a_max    in   3*W   box A max corner {z,y,x}
//   b_min    in   3*W   box B min corner {z,y,x}
//   b_max    in   3*W   box B max corner {z,y,x}
//   hi       out  W     minuend for the borrow subtractor
//   lo       out  W     subtrahend for the borrow subtractor
//   axis     out  2     axis tested by this compare
// -----------------------------------------------------------------------------
module aabb_cmp_sel #(
    parameter int W = 32
) (
    input  logic [2:0]     idx,
    input  logic [3*W-1:0] a_min,
    input  logic [3*W-1:0] a_max,
    input  logic [3*W-1:0] b_min,
    input  logic [3*W-1:0] b_max,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo,
    output logic [1:0]     axis
);
    import coll_det_pkg::*;

    // Per-axis views of the packed corners. Slot 3 is a zero filler so the
    // 2-bit axis index always addresses a valid entry (idx 6/7 never occur).
    logic [W-1:0] a_min_ax [0:3];
    logic [W-1:0] a_max_ax [0:3];
    logic [W-1:0] b_min_ax [0:3];
    logic [W-1:0] b_max_ax [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis_slice
            assign a_min_ax[gi] = a_min[gi*W +: W];
            assign a_max_ax[gi] = a_max[gi*W +: W];
            assign b_min_ax[gi] = b_min[gi*W +: W];
            assign b_max_ax[gi] = b_max[gi*W +: W];
        end
    endgenerate

    assign a_min_ax[3] = '0;
    assign a_max_ax[3] = '0;
    assign b_min_ax[3] = '0;
    assign b_max_ax[3] = '0;

    always_comb begin
        axis = idx_to_axis(idx);
        if (idx[0] == 1'b0) begin
            // B's top must reach A's bottom.
            hi = b_max_ax[axis];
            lo = a_min_ax[axis];
        end else begin
            // A's top must reach B's bottom.
            hi = a_max_ax[axis];
            lo = b_min_ax[axis];
        end
    end

endmodule

// File: rtl/aabb_overlap_seq.sv
// -----------------------------------------------------------------------------
// aabb_overlap_seq
//
// Sequential axis-aligned bounding-box overlap checker. A request captures two
// 3-D boxes; the block then walks the six interval compares (x, y, z; two per
// axis), one borrow subtraction per cycle, and reports hit/miss. On a miss it
// reports the first separating axis and the gap (lo - hi) along it. Touching
// faces (equal coordinates) count as overlap.
//
// Build option
//   AABB_EARLY_EXIT_EN : when defined, the scan stops in the cycle the first
//                        separation is registered. Otherwise all six compares
//                        always run (constant 6-cycle latency). Results are
//                        identical either way.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     request valid
//   in_ready   out  1     request accepted when high (IDLE only)
//   a_min      in   3*W   box A min corner {z,y,x}
//   a_max      in   3*W   box A max corner {z,y,x}
//   b_min      in   3*W   box B min corner {z,y,x}
//   b_max      in   3*W   box B max corner {z,y,x}
//   out_valid  out  1     result valid (DONE)
//   out_ready  in   1     consumer takes the result
//   hit        out  1     1 = boxes overlap
//   sep_axis   out  2     0 = x, 1 = y, 2 = z, 3 = none
//   sep_gap    out  W     gap along the first separating axis; 0 on hit
// -----------------------------------------------------------------------------
module aabb_overlap_seq #(
    parameter int W = coll_det_pkg::W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*W-1:0] a_min,
    input  logic [3*W-1:0] a_max,
    input  logic [3*W-1:0] b_min,
    input  logic [3*W-1:0] b_max,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           hit,
    output logic [1:0]     sep_axis,
    output logic [W-1:0]   sep_gap
);
    import coll_det_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    aabb_state_t    state_q;
    logic [2:0]     idx_q;
    logic [3*W-1:0] a_min_q;
    logic [3*W-1:0] a_max_q;
    logic [3*W-1:0] b_min_q;
    logic [3*W-1:0] b_max_q;
    logic           hit_q;
    logic [1:0]     sep_axis_q;
    logic [W-1:0]   gap_q;

    // ------------------------------------------------------------------
    // Operand select and borrow subtraction
    // ------------------------------------------------------------------
    logic [W-1:0] cmp_hi;
    logic [W-1:0] cmp_lo;
    logic [1:0]   cmp_axis;

    aabb_cmp_sel #(
        .W (W)
    ) u_cmp_sel (
        .idx   (idx_q),
        .a_min (a_min_q),
        .a_max (a_max_q),
        .b_min (b_min_q),
        .b_max (b_max_q),
        .hi    (cmp_hi),
        .lo    (cmp_lo),
        .axis  (cmp_axis)
    );

    // Zero-extended W+1-bit subtraction: the top bit is the borrow, set
    // exactly when lo > hi (the intervals are separated on this side).
    logic [W:0]   sub_res;
    logic         sub_borrow;
    logic [W-1:0] sub_diff;
    logic [W-1:0] gap_d;

    assign sub_res    = {1'b0, cmp_hi} - {1'b0, cmp_lo};
    assign sub_borrow = sub_res[W];
    assign sub_diff   = sub_res[W-1:0];

    // lo - hi as the two's-complement negation of the W-bit difference.
    // Only used when borrow is set, so it is nonzero and never wraps.
    assign gap_d = (~sub_diff) + {{(W-1){1'b0}}, 1'b1};

    // Only the first separation is recorded; hit_q still high means none yet.
    logic first_sep_d;
    logic scan_done_d;

    assign first_sep_d = (state_q == CMP) && sub_borrow && hit_q;

`ifdef AABB_EARLY_EXIT_EN
    assign scan_done_d = (idx_q == LAST_IDX) || first_sep_d;
`else
    assign scan_done_d = (idx_q == LAST_IDX);
`endif

    // ------------------------------------------------------------------
    // Control FSM and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_min_q    <= '0;
            a_max_q    <= '0;
            b_min_q    <= '0;
            b_max_q    <= '0;
            hit_q      <= 1'b0;
            sep_axis_q <= AXIS_NONE;
            gap_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_min_q    <= a_min;
                        a_max_q    <= a_max;
                        b_min_q    <= b_min;
                        b_max_q    <= b_max;
                        idx_q      <= '0;
                        hit_q      <= 1'b1;
                        sep_axis_q <= AXIS_NONE;
                        gap_q      <= '0;
                        state_q    <= CMP;
                    end
                end

                CMP: begin
                    if (first_sep_d) begin
                        hit_q      <= 1'b0;
                        sep_axis_q <= cmp_axis;
                        gap_q      <= gap_d;
                    end
                    if (scan_done_d) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end

                DONE: begin
                    // Result registers are untouched here, so outputs hold
                    // while the consumer stalls.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign hit       = hit_q;
    assign sep_axis  = sep_axis_q;
    assign sep_gap   = gap_q;

endmodule

// File: tb/tb_aabb_overlap_seq.sv
module tb_aabb_overlap_seq;
    import coll_det_pkg::*;

    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3*TW-1:0] a_min, a_max, b_min, b_max;
    logic            out_valid;
    logic            out_ready;
    logic            hit;
    logic [1:0]      sep_axis;
    logic [TW-1:0]   sep_gap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          hit;
        logic [1:0]    axis;
        logic [TW-1:0] gap;
        int            lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    aabb_overlap_seq #(.W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_min     (a_min),
        .a_max     (a_max),
        .b_min     (b_min),
        .b_max     (b_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit       (hit),
        .sep_axis  (sep_axis),
        .sep_gap   (sep_gap)
    );

    function automatic logic [3*TW-1:0] v3(input logic [TW-1:0] z, input logic [TW-1:0] y,
                                            input logic [TW-1:0] x);
        return {z, y, x};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_hit"},       64'(hit),       64'd0);
        chk({tag, "_sep_axis"},  64'(sep_axis),  64'd3);
        chk({tag, "_sep_gap"},   64'(sep_gap),   64'd0);
    endtask

    // k_first: index of the first failing compare, -1 if none.
    task automatic run_req(input string tag,
                           input aabb_box_t ba, input aabb_box_t bb,
                           input logic eh, input logic [1:0] eax,
                           input logic [TW-1:0] egap, input int k_first,
                           input int hold_cycles);
        exp_t e;
        exp_t got;
        int   lat;
        int   w;
        e.hit  = eh;
        e.axis = eax;
        e.gap  = egap;
`ifdef AABB_EARLY_EXIT_EN
        e.lat  = (k_first >= 0) ? k_first + 1 : 6;
`else
        e.lat  = 6;
`endif
        sb_q.push_back(e);

        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_idle_wait"}, 64'(in_ready), 64'd1);

        a_min    = ba.bmin;
        a_max    = ba.bmax;
        b_min    = bb.bmin;
        b_max    = bb.bmax;
        in_valid = 1'b1;
        @(posedge clk); #1;   // accept edge T
        // Keep in_valid high with junk operands: must be ignored outside IDLE.
        a_min = {3*TW{1'b1}};
        a_max = '0;
        b_min = {3*TW{1'b1}};
        b_max = '0;

        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(e.lat));

        got = sb_q.pop_front();
        chk({tag, "_hit"},      64'(hit),      64'(got.hit));
        chk({tag, "_sep_axis"}, 64'(sep_axis), 64'(got.axis));
        chk({tag, "_sep_gap"},  64'(sep_gap),  64'(got.gap));
        chk({tag, "_busy"},     64'(in_ready), 64'd0);

        for (int h = 0; h < hold_cycles; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_hit"},   64'(hit),       64'(got.hit));
            chk({tag, "_hold_axis"},  64'(sep_axis),  64'(got.axis));
            chk({tag, "_hold_gap"},   64'(sep_gap),   64'(got.gap));
            chk({tag, "_hold_busy"},  64'(in_ready),  64'd0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(in_ready),  64'd1);
        $display("req %s: hit=%0d axis=%0d gap=%0h latency=%0d", tag, hit, sep_axis, sep_gap, lat);
    endtask

    aabb_box_t box_a, box_b;
    int        seen_valid;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_min = '0; a_max = '0; b_min = '0; b_max = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Plain overlap: full scan.
        box_a.bmin = v3(0, 0, 0);    box_a.bmax = v3(10, 10, 10);
        box_b.bmin = v3(5, 5, 5);    box_b.bmax = v3(15, 15, 15);
        run_req("overlap", box_a, box_b, 1'b1, 2'd3, 32'd0, -1, 0);

        // Separated on x, B above A: compare 1 fails, gap 20-10.
        box_b.bmin = v3(5, 5, 20);   box_b.bmax = v3(15, 15, 30);
        run_req("sep_x", box_a, box_b, 1'b0, 2'd0, 32'd10, 1, 0);

        // Touching z faces count as overlap.
        box_b.bmin = v3(10, 5, 5);   box_b.bmax = v3(20, 15, 15);
        run_req("touch_z", box_a, box_b, 1'b1, 2'd3, 32'd0, -1, 0);

        // Extreme: lo = all ones, hi = 0 on compare 0.
        box_a.bmin = v3(0, 0, 32'hFFFF_FFFF);  box_a.bmax = v3(10, 10, 32'hFFFF_FFFF);
        box_b.bmin = v3(0, 0, 0);              box_b.bmax = v3(10, 10, 0);
        run_req("extreme_sep", box_a, box_b, 1'b0, 2'd0, 32'hFFFF_FFFF, 0, 0);

        // Extreme: lo = 0, hi = all ones is overlap.
        box_a.bmin = v3(0, 0, 0);    box_a.bmax = v3(10, 10, 32'hFFFF_FFFF);
        box_b.bmin = v3(0, 0, 0);    box_b.bmax = v3(10, 10, 32'hFFFF_FFFF);
        run_req("extreme_hit", box_a, box_b, 1'b1, 2'd3, 32'd0, -1, 0);

        // B below A on y: even compare 2 fails, gap 5-2.
        box_a.bmin = v3(0, 5, 0);    box_a.bmax = v3(10, 10, 10);
        box_b.bmin = v3(0, 0, 0);    box_b.bmax = v3(10, 2, 10);
        run_req("sep_y_below", box_a, box_b, 1'b0, 2'd1, 32'd3, 2, 0);

        // y gap 3 and z gap 7: first (y) wins; stall consumer 4 cycles.
        box_a.bmin = v3(0, 0, 0);    box_a.bmax = v3(10, 10, 10);
        box_b.bmin = v3(17, 13, 5);  box_b.bmax = v3(20, 20, 15);
        run_req("sep_yz_hold", box_a, box_b, 1'b0, 2'd1, 32'd3, 3, 4);

        // Reset in the middle of compare 2: no result, reset values.
        a_min = v3(0, 0, 0);  a_max = v3(10, 10, 10);
        b_min = v3(5, 5, 20); b_max = v3(15, 15, 30);
        in_valid = 1'b1;
        @(posedge clk); #1;   // accept edge T
        in_valid = 1'b0;
        @(posedge clk); #1;   // compare 0 registered
        @(posedge clk); #1;   // compare 1 registered; compare 2 in flight
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        chk("mid_rst_no_result", 64'(seen_valid), 64'd0);
        chk_reset_outputs("after_rst");
        $display("req mid_rst: aborted, out_valid seen %0d times", seen_valid);

        // Next request completes normally.
        box_a.bmin = v3(0, 0, 0);    box_a.bmax = v3(10, 10, 10);
        box_b.bmin = v3(5, 5, 20);   box_b.bmax = v3(15, 15, 30);
        run_req("post_rst", box_a, box_b, 1'b0, 2'd0, 32'd10, 1, 0);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
